// File: rtl/si_tag_serializer_if.sv
// Stream interfaces around the tag serializer: a multi-lane sparse beat in, one tag per beat out.
interface si_tag_beat_if #(parameter int NUMBER_OF_WORDS = 4);
    logic                                tvalid;
    logic                                tready;
    logic [NUMBER_OF_WORDS-1:0][63:0]    tagtime;
    logic [NUMBER_OF_WORDS-1:0][5:0]     channel;
    logic [NUMBER_OF_WORDS-1:0]          tkeep;

    modport master (output tvalid, tagtime, channel, tkeep, input tready);
    modport slave  (input tvalid, tagtime, channel, tkeep, output tready);
endinterface

interface si_tag_stream_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tagtime;
    logic [5:0]  channel;
    logic        tlast;

    modport master (output tvalid, tagtime, channel, tlast, input tready);
    modport slave  (input tvalid, tagtime, channel, tlast, output tready);
endinterface

// File: rtl/si_tag_serializer.sv
// Serializes sparse multi-lane tag beats into one tag per cycle in lane order, and forwards a
// monotonic time bound that never passes a tag still held here.
module si_tag_serializer #(
    parameter int NUMBER_OF_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    si_tag_beat_if.slave         s_axis,
    input  logic [63:0]          s_lowest_time_bound,
    si_tag_stream_if.master      m_axis,
    output logic [63:0]          lowest_time_bound
);
    localparam int N = NUMBER_OF_WORDS;

    logic [N-1:0][63:0] hold_time;
    logic [N-1:0][5:0]  hold_chan;
    logic [N-1:0]       pend;
    logic [N-1:0]       head_oh;
    logic [63:0]        head_time;
    logic [5:0]         head_chan;
    logic [63:0]        cand;
    logic               accept;
    logic               pop;

    // Lowest set bit of the remaining-lane mask is the next tag in time order.
    assign head_oh = pend & (~pend + N'(1));

    always_comb begin
        head_time = '0;
        head_chan = '0;
        for (int i = 0; i < N; i++) begin
            if (head_oh[i]) begin
                head_time = hold_time[i];
                head_chan = hold_chan[i];
            end
        end
    end

    assign m_axis.tvalid  = |pend;
    assign m_axis.tagtime = head_time;
    assign m_axis.channel = head_chan;
    assign m_axis.tlast   = (|pend) && ((pend & (pend - N'(1))) == '0);

    // Taking a new beat while the last tag pops keeps throughput at one tag per cycle.
    assign s_axis.tready  = (pend == '0) || (m_axis.tlast && m_axis.tready);

    assign accept = s_axis.tvalid && s_axis.tready;
    assign pop    = m_axis.tvalid && m_axis.tready;

    // While a tag is held, its time caps the bound; otherwise pass the upstream bound through.
    assign cand = (|pend) ? head_time : s_lowest_time_bound;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend              <= '0;
            lowest_time_bound <= '0;
        end else begin
            if (accept)
                pend <= s_axis.tkeep;
            else if (pop)
                pend <= pend & ~head_oh;
            if (cand > lowest_time_bound)
                lowest_time_bound <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_time <= s_axis.tagtime;
            hold_chan <= s_axis.channel;
        end
    end
endmodule

// File: tb/tb_si_tag_serializer.sv
// Bench for si_tag_serializer: scoreboard of expected tags fed on beat accept, checked on pop.
module tb_si_tag_serializer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_bound;
    logic [63:0] bound;

    always #5 clk = ~clk;

    si_tag_beat_if #(.NUMBER_OF_WORDS(N)) s_axis ();
    si_tag_stream_if m_axis ();

    si_tag_serializer #(.NUMBER_OF_WORDS(N)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis              (s_axis),
        .s_lowest_time_bound (s_bound),
        .m_axis              (m_axis),
        .lowest_time_bound   (bound)
    );

    typedef struct {
        logic [63:0] t;
        logic [5:0]  c;
        logic        last;
    } exp_t;

    typedef struct {
        logic [3:0]  keep;
        logic [63:0] base;
        int          exp_n;
    } vec_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          npop = 0;
    bit          last_acc;
    bit          prev_stall = 0;
    logic [63:0] prev_t;
    logic [5:0]  prev_c;
    logic        prev_l;
    logic [63:0] prev_bound = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input logic [63:0] a, input logic [63:0] b);
        tests++;
        if (!(a <= b)) begin
            fails++;
            $display("FAIL %s: got %0d expected at most %0d", name, a, b);
        end
    endtask

    // One clock: observe settled outputs, model the handshakes, advance to the next negedge.
    task automatic cycle();
        exp_t e;
        int   cnt;
        #1;
        last_acc = 0;
        if (rst) begin
            q.delete();
            prev_stall = 0;
            prev_bound = 0;
        end else begin
            chk("valid_vs_model", m_axis.tvalid, q.size() != 0);
            chk("s_tready_vs_model", s_axis.tready,
                (q.size() == 0) || (q.size() == 1 && m_axis.tready));
            if (prev_stall) begin
                chk("stall_time", m_axis.tagtime, prev_t);
                chk("stall_chan", m_axis.channel, prev_c);
                chk("stall_last", m_axis.tlast, prev_l);
            end
            if (q.size() > 0) chk_le("bound_below_pending", bound, q[0].t);
            chk_le("bound_monotonic", prev_bound, bound);
            if (m_axis.tvalid && m_axis.tready) begin
                npop++;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_pop: got tag %0d expected none", m_axis.tagtime);
                end else begin
                    e = q.pop_front();
                    chk("pop_time", m_axis.tagtime, e.t);
                    chk("pop_chan", m_axis.channel, e.c);
                    chk("pop_last", m_axis.tlast, e.last);
                end
            end
            if (s_axis.tvalid && s_axis.tready) begin
                last_acc = 1;
                cnt = 0;
                for (int i = 0; i < N; i++) if (s_axis.tkeep[i]) cnt++;
                for (int i = 0; i < N; i++) begin
                    if (s_axis.tkeep[i]) begin
                        cnt--;
                        e.t = s_axis.tagtime[i];
                        e.c = s_axis.channel[i];
                        e.last = (cnt == 0);
                        q.push_back(e);
                    end
                end
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_t = m_axis.tagtime;
            prev_c = m_axis.channel;
            prev_l = m_axis.tlast;
            prev_bound = bound;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [3:0] keep, input logic [63:0] base, input logic [63:0] step);
        s_axis.tkeep = keep;
        for (int i = 0; i < N; i++) begin
            s_axis.tagtime[i] = base + 64'(i) * step;
            s_axis.channel[i] = 6'(i + 1);
        end
    endtask

    task automatic send();
        bit done = 0;
        s_axis.tvalid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            done = last_acc;
        end
        s_axis.tvalid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) cycle();
        chk("drain_empty", q.size(), 0);
        cycle();
    endtask

    vec_t vecs[5];
    int   pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int   p0;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{keep: 4'b1111, base: 64'd1000, exp_n: 4};
        vecs[1] = '{keep: 4'b0110, base: 64'd1100, exp_n: 2};
        vecs[2] = '{keep: 4'b1000, base: 64'd1200, exp_n: 1};
        vecs[3] = '{keep: 4'b0101, base: 64'd1300, exp_n: 2};
        vecs[4] = '{keep: 4'b0000, base: 64'd1400, exp_n: 0};

        s_axis.tvalid = 0; s_axis.tkeep = 0; s_axis.tagtime = '0; s_axis.channel = '0;
        m_axis.tready = 1; s_bound = 0;
        @(negedge clk);
        cycle(); cycle();
        #1;
        chk("reset_valid", m_axis.tvalid, 0);
        chk("reset_last", m_axis.tlast, 0);
        chk("reset_bound", bound, 0);
        chk("reset_s_tready", s_axis.tready, 1);
        rst = 0;

        // 1: sparse beat 1011, tready low for two cycles after accept
        s_axis.tkeep = 4'b1011;
        s_axis.tagtime[0] = 10; s_axis.tagtime[1] = 20; s_axis.tagtime[2] = 99; s_axis.tagtime[3] = 40;
        s_axis.channel[0] = 6'd1; s_axis.channel[1] = 6'h3E; s_axis.channel[2] = 6'd0; s_axis.channel[3] = 6'd5;
        send();
        #1 chk("t1_s_tready_c1", s_axis.tready, 0);
        cycle();
        #1 chk("t1_s_tready_c2", s_axis.tready, 0);
        cycle();
        #1 chk("t1_s_tready_c3", s_axis.tready, 1);
        chk("t1_last_tag", m_axis.tagtime, 40);
        drain();

        // 2: back-to-back single-tag beats, no bubbles
        for (int i = 0; i < 4; i++) begin
            set_beat(4'b0001, 64'd100 + 64'(i) * 10, 1);
            s_axis.tvalid = 1;
            #1;
            chk("t2_s_tready", s_axis.tready, 1);
            if (i > 0) chk("t2_no_bubble", m_axis.tvalid, 1);
            cycle();
        end
        s_axis.tvalid = 0;
        drain();

        // table: tag count per beat pattern
        foreach (vecs[v]) begin
            p0 = npop;
            set_beat(vecs[v].keep, vecs[v].base, 10);
            send();
            drain();
            chk("vec_tag_count", npop - p0, vecs[v].exp_n);
        end

        // 3: full beat under toggling m_tready
        set_beat(4'b1111, 64'd2000, 10);
        send();
        p0 = npop;
        for (int k = 0; k < 30 && q.size() != 0; k++) begin
            m_axis.tready = pat[k % 7] != 0;
            cycle();
        end
        m_axis.tready = 1;
        chk("t3_pops", npop - p0, 4);
        drain();

        // 4: bound ramp while idle, then capped by a pending tag
        rst = 1; cycle(); rst = 0;
        s_bound = 100; cycle();
        #1 chk("t4_bound_100", bound, 100);
        s_bound = 200; cycle();
        #1 chk("t4_bound_200", bound, 200);
        s_bound = 150; cycle();
        #1 chk("t4_bound_hold", bound, 200);
        m_axis.tready = 0;
        set_beat(4'b0001, 64'd300, 1);
        send();
        s_bound = 500;
        cycle(); cycle();
        #1 chk("t4_bound_capped", bound, 300);
        m_axis.tready = 1;
        cycle(); cycle();
        #1 chk("t4_bound_after_pop", bound, 500);

        // 5: empty beat accepted, next beat right after
        set_beat(4'b0000, 64'd600, 1);
        s_axis.tvalid = 1;
        cycle();
        chk("t5_empty_accepted", last_acc, 1);
        #1 chk("t5_no_valid", m_axis.tvalid, 0);
        set_beat(4'b0001, 64'd600, 1);
        cycle();
        chk("t5_next_accepted", last_acc, 1);
        s_axis.tvalid = 0;
        drain();

        // 6: reset with three tags pending
        m_axis.tready = 0;
        set_beat(4'b0111, 64'd700, 10);
        send();
        cycle();
        rst = 1; cycle(); rst = 0;
        #1;
        chk("t6_valid_after_rst", m_axis.tvalid, 0);
        chk("t6_bound_after_rst", bound, 0);
        chk("t6_s_tready_after_rst", s_axis.tready, 1);
        s_bound = 0;
        m_axis.tready = 1;
        set_beat(4'b0011, 64'd50, 5);
        p0 = npop;
        send();
        drain();
        chk("t6_pops_after_rst", npop - p0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
